sigmoid_bwd_piped: RTL and testbench
====================================

// Module: sigmoid_bwd_piped
// PURPOSE
//   Backward-pass companion to the pipelined PWL sigmoid forward block.
//   Takes a stored sigmoid output y and an upstream gradient g and returns dL/dx = g*y*(1-y).
//   Fixed-point 3-stage pipeline with valid/ready handshakes on both sides.
//   Sits between the activation store and the weight-update datapath.
// PARAMETERS
//   BITSIZE  16  word width. Sign-magnitude: bit BITSIZE-1 = sign, remaining bits = magnitude.
//   FRAC     11  fractional bits of the magnitude. ONE = 1<<FRAC = 0x0800.
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous, active-high
//   in_valid   in   1        y_in/g_in valid
//   in_ready   out  1        block accepts input this cycle
//   y_in       in   BITSIZE  sigmoid output y, sign-magnitude
//   g_in       in   BITSIZE  upstream gradient g, sign-magnitude
//   out_valid  out  1        grad_out valid
//   out_ready  in   1        downstream accepts grad_out
//   grad_out   out  BITSIZE  g*y*(1-y), sign-magnitude
// BEHAVIOUR
//   - Reset: reset is asynchronous and active-high; the clock is clk.
//     While reset is high: all stage valids = 0, all data regs = 0, out_valid = 0, grad_out = 0.
//     in_ready goes to 1 once reset is low.
//   - Reset mid-operation: in-flight items are dropped; no output is produced for them.
//   - Handshake: input transfer when in_valid && in_ready.
//     Output transfer when out_valid && out_ready.
//   - Stall: stall = out_valid && !out_ready; in_ready = !stall (combinational).
//     On stall, all stage regs hold and grad_out/out_valid stay stable.
//     Otherwise every stage advances each cycle. Bubbles (valid=0) advance and are not collapsed.
//   - Latency: 3 cycles from accepted input to out_valid, with no stalls.
//     Throughput: 1 item/cycle.
//   - S1: clamp y.
//     If y sign bit is set, ym = 0. If y magnitude > ONE, ym = ONE. Otherwise ym = y magnitude.
//     Register ym, om = ONE - ym, gs = g sign, gm = g magnitude, v1.
//   - S2: p = (ym*om) >> FRAC. Full product is 2*(BITSIZE-1) bits. p <= ONE/4.
//     Register p, gs, gm, v2.
//   - S3: q = (gm*p) >> FRAC.
//     If q > 2^(BITSIZE-1)-1, saturate q to all-ones magnitude.
//     Register grad_out = {gs, q}, out_valid = v2.
//   - Negative zero: if q == 0, grad_out = 0 (sign bit forced to 0).
//   - y outside [0, ONE] is clamped, not flagged.
//   - g = 0 with either sign gives grad_out = 0.
//   - Simultaneous input accept and output drain in the same cycle is allowed; no bubble is inserted.
// CONFIGURATION
//   SIGMOID_BWD_ROUND_EN
//     defined: both shifts round half-up: (prod + (1<<(FRAC-1))) >> FRAC, then S3 saturation.
//     undefined: both shifts truncate toward zero on magnitude. Default build.
//   Handshake, latency and ports are identical in both builds.
// TESTING
//   1. y=0x0400, g=0x0800, out_ready=1
//      -> p=0x0200; out_valid 3 cycles after accept, grad_out=0x0200.
//   2. y=0x0400, g=0x8800
//      -> grad_out=0x8200. y=0x0800, g=0x8800 -> grad_out=0x0000 (no -0).
//   3. y=0x0001, g=0x0800
//      -> grad_out=0x0000 (truncate); 0x0001 with SIGMOID_BWD_ROUND_EN.
//      y=0x8123 -> grad_out=0x0000. y=0x0C00 -> grad_out=0x0000.
//   4. Stream 6 items back-to-back with out_ready=1 -> 6 results on consecutive cycles, in order.
//   5. Backpressure: out_ready=0 while 3 items are in flight
//      -> out_valid=1 and grad_out stable, in_ready=0.
//      Release out_ready -> all items drain in order, none lost or duplicated.
//   6. Assert reset with 2 items in flight -> out_valid=0 immediately.
//      After reset is released, a fresh item appears after 3 cycles; the old items never appear.

Source files
------------

// File: rtl/sigmoid_bwd_piped.sv
// ---------------------------------------------------------------------------
// sigmoid_bwd_piped
//   Backward pass of the PWL sigmoid: grad_out = g * y * (1 - y).
//   Three-stage fixed-point pipeline with valid/ready handshakes on both sides.
//   Words are sign-magnitude: bit BITSIZE-1 is the sign and the rest is the
//   magnitude, which has FRAC fractional bits.
//
//   S1: clamp y into [0, ONE], form 1-y, split g into sign and magnitude.
//   S2: p = y*(1-y), rescaled back to FRAC fractional bits.
//   S3: q = |g|*p, rescaled and saturated; a zero result is forced positive.
//
// Build option:
//   SIGMOID_BWD_ROUND_EN  defined   -> both rescales round half-up
//                         undefined -> both rescales truncate (default)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   y_in/g_in valid
//   in_ready   out  block accepts input this cycle
//   y_in       in   stored sigmoid output y
//   g_in       in   upstream gradient g
//   out_valid  out  grad_out valid
//   out_ready  in   downstream accepts grad_out
//   grad_out   out  g*y*(1-y)
// ---------------------------------------------------------------------------
module sigmoid_bwd_piped #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] y_in,
  input  logic [BITSIZE-1:0] g_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] grad_out
);

  localparam int MAG_W  = BITSIZE - 1;
  localparam int PROD_W = 2 * MAG_W;

  localparam logic [MAG_W-1:0]  ONE_M = MAG_W'(1 << FRAC);
`ifdef SIGMOID_BWD_ROUND_EN
  localparam logic [PROD_W:0]   HALF  = (PROD_W + 1)'(1 << (FRAC - 1));
`endif

  // Stage registers
  logic             v1_q, v1_d;
  logic [MAG_W-1:0] ym_q, ym_d;
  logic [MAG_W-1:0] om_q, om_d;
  logic             gs1_q, gs1_d;
  logic [MAG_W-1:0] gm1_q, gm1_d;

  logic             v2_q, v2_d;
  logic [MAG_W-1:0] p_q, p_d;
  logic             gs2_q, gs2_d;
  logic [MAG_W-1:0] gm2_q, gm2_d;

  logic               out_valid_q, out_valid_d;
  logic [BITSIZE-1:0] grad_q, grad_d;

  // Handshake
  logic stall, advance, take;

  assign stall   = out_valid_q & ~out_ready;
  assign advance = ~stall;
  // Held low during reset so nothing is offered acceptance while flushing.
  assign in_ready = ~reset & ~stall;
  assign take     = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign grad_out  = grad_q;

  // S1 combinational: clamp y
  logic [MAG_W-1:0] y_mag, ym_new;

  always_comb begin
    y_mag = y_in[MAG_W-1:0];
    if (y_in[BITSIZE-1]) begin
      ym_new = '0;
    end else if (y_mag > ONE_M) begin
      ym_new = ONE_M;
    end else begin
      ym_new = y_mag;
    end
  end

  // S2 combinational: p = y*(1-y) rescaled
  logic [PROD_W-1:0] prod1;
  logic [PROD_W:0]   prod1_ext;
  logic [PROD_W:0]   p_full;
  logic [MAG_W-1:0]  p_new;

  always_comb begin
    prod1 = PROD_W'(ym_q) * PROD_W'(om_q);
`ifdef SIGMOID_BWD_ROUND_EN
    prod1_ext = {1'b0, prod1} + HALF;
`else
    prod1_ext = {1'b0, prod1};
`endif
    p_full = prod1_ext >> FRAC;
    // p never exceeds ONE/4; the clamp only keeps the narrowing explicit.
    if (|p_full[PROD_W:MAG_W]) begin
      p_new = '1;
    end else begin
      p_new = p_full[MAG_W-1:0];
    end
  end

  // S3 combinational: q = |g|*p rescaled and saturated
  logic [PROD_W-1:0]  prod2;
  logic [PROD_W:0]    prod2_ext;
  logic [PROD_W:0]    q_full;
  logic [MAG_W-1:0]   q_mag;
  logic [BITSIZE-1:0] grad_new;

  always_comb begin
    prod2 = PROD_W'(gm2_q) * PROD_W'(p_q);
`ifdef SIGMOID_BWD_ROUND_EN
    prod2_ext = {1'b0, prod2} + HALF;
`else
    prod2_ext = {1'b0, prod2};
`endif
    q_full = prod2_ext >> FRAC;
    if (|q_full[PROD_W:MAG_W]) begin
      q_mag = '1;
    end else begin
      q_mag = q_full[MAG_W-1:0];
    end
    // A zero magnitude is always reported as +0.
    if (q_mag == '0) begin
      grad_new = '0;
    end else begin
      grad_new = {gs2_q, q_mag};
    end
  end

  // Next-state: everything holds on stall; otherwise every stage moves,
  // bubbles included. Data regs only load when a valid item arrives, so the
  // output word stays at the last result while bubbles pass.
  always_comb begin
    v1_d        = v1_q;
    ym_d        = ym_q;
    om_d        = om_q;
    gs1_d       = gs1_q;
    gm1_d       = gm1_q;
    v2_d        = v2_q;
    p_d         = p_q;
    gs2_d       = gs2_q;
    gm2_d       = gm2_q;
    out_valid_d = out_valid_q;
    grad_d      = grad_q;

    if (advance) begin
      v1_d        = take;
      v2_d        = v1_q;
      out_valid_d = v2_q;

      if (take) begin
        ym_d  = ym_new;
        om_d  = ONE_M - ym_new;
        gs1_d = g_in[BITSIZE-1];
        gm1_d = g_in[MAG_W-1:0];
      end

      if (v1_q) begin
        p_d   = p_new;
        gs2_d = gs1_q;
        gm2_d = gm1_q;
      end

      if (v2_q) begin
        grad_d = grad_new;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      ym_q        <= '0;
      om_q        <= '0;
      gs1_q       <= 1'b0;
      gm1_q       <= '0;
      v2_q        <= 1'b0;
      p_q         <= '0;
      gs2_q       <= 1'b0;
      gm2_q       <= '0;
      out_valid_q <= 1'b0;
      grad_q      <= '0;
    end else begin
      v1_q        <= v1_d;
      ym_q        <= ym_d;
      om_q        <= om_d;
      gs1_q       <= gs1_d;
      gm1_q       <= gm1_d;
      v2_q        <= v2_d;
      p_q         <= p_d;
      gs2_q       <= gs2_d;
      gm2_q       <= gm2_d;
      out_valid_q <= out_valid_d;
      grad_q      <= grad_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_bwd_piped.sv
module tb_sigmoid_bwd_piped;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y_in;
  logic [15:0] g_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] grad_out;

  sigmoid_bwd_piped dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .g_in      (g_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_grad  = 16'h0;
  logic        last_xfer  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued rules on integers (ONE = 2048).
  function automatic int unsigned rescale(input longint unsigned x);
`ifdef SIGMOID_BWD_ROUND_EN
    return int'((x + 1024) / 2048);
`else
    return int'(x / 2048);
`endif
  endfunction

  function automatic logic [15:0] ref_grad(input logic [15:0] y, input logic [15:0] g);
    int unsigned ym, om, p, q;
    if (y[15])                  ym = 0;
    else if (y[14:0] > 15'd2048) ym = 2048;
    else                        ym = y[14:0];
    om = 2048 - ym;
    p  = rescale(longint'(ym) * longint'(om));
    q  = rescale(longint'(g[14:0]) * longint'(p));
    if (q > 32767) q = 32767;
    if (q == 0) return 16'h0000;
    return {g[15], q[14:0]};
  endfunction

  // One clock of stimulus; transfers are judged just before the next rising edge.
  task automatic cycle(input logic iv, input logic [15:0] y, input logic [15:0] g,
                       input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    y_in      = y;
    g_in      = g;
    out_ready = ordy;
    #1;
    if (prev_stall)
      chk("hold", {15'h0, out_valid, grad_out}, {15'h0, 1'b1, prev_grad});
    chk("in_ready", {31'h0, in_ready}, {31'h0, !(out_valid && !out_ready)});
    last_xfer = out_valid && out_ready;
    if (last_xfer) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else                   chk("grad", {16'h0, grad_out}, {16'h0, exp_q.pop_front()});
    end
    if (in_valid && in_ready) exp_q.push_back(ref_grad(y, g));
    prev_stall = out_valid && !out_ready;
    prev_grad  = grad_out;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Single item on an empty pipe: checks latency and value.
  task automatic send_lat(input string tag, input logic [15:0] y, input logic [15:0] g,
                          input logic [15:0] exp);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; y_in = y; g_in = g; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'h0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_val"}, {16'h0, grad_out}, {16'h0, exp});
    prev_stall = 1'b0;
  endtask

  logic [15:0] ry, rg;
  logic [10:0] mask;

  initial begin
    reset = 1'b1; in_valid = 1'b0; y_in = '0; g_in = '0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_grad", {16'h0, grad_out}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);

    // Directed values
    send_lat("t1", 16'h0400, 16'h0800, 16'h0200);
    send_lat("t2a", 16'h0400, 16'h8800, 16'h8200);
    send_lat("t2b", 16'h0800, 16'h8800, 16'h0000);
`ifdef SIGMOID_BWD_ROUND_EN
    send_lat("t3a", 16'h0001, 16'h0800, 16'h0001);
`else
    send_lat("t3a", 16'h0001, 16'h0800, 16'h0000);
`endif
    send_lat("t3b", 16'h8123, 16'h0800, 16'h0000);
    send_lat("t3c", 16'h0C00, 16'h0800, 16'h0000);
    send_lat("gzero_neg", 16'h0400, 16'h8000, 16'h0000);
    send_lat("gmax", 16'h0400, 16'h7FFF, ref_grad(16'h0400, 16'h7FFF));
    drain();

    // Back-to-back stream of 6: results on 6 consecutive cycles
    mask = '0;
    for (int c = 0; c < 11; c++) begin
      ry = 16'($urandom_range(0, 16'h0900));
      rg = 16'($urandom);
      cycle(c < 6, ry, rg, 1'b1);
      mask[c] = last_xfer;
    end
    chk("stream_timing", {21'h0, mask}, {21'h0, 11'b00111111000});
    drain();

    // Backpressure with 3 in flight
    for (int c = 0; c < 3; c++) cycle(1'b1, 16'($urandom_range(0, 16'h0800)), 16'($urandom), 1'b0);
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 16'h0400, 16'h0800, 1'b0);
      chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
    end
    chk("bp_inflight", exp_q.size(), 3);
    drain();

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      ry = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0900));
      rg = 16'($urandom);
      cycle($urandom_range(0, 3) != 0, ry, rg, $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset with 2 items in flight
    cycle(1'b1, 16'h0400, 16'h0800, 1'b1);
    cycle(1'b1, 16'h0300, 16'h0800, 1'b1);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_grad", {16'h0, grad_out}, 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send_lat("after_rst", 16'h0200, 16'h0800, ref_grad(16'h0200, 16'h0800));
    for (int c = 0; c < 8; c++) cycle(1'b0, 16'h0, 16'h0, 1'b1);
    chk("after_rst_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
